// File: rtl/switch_event_scheduler.sv
// -----------------------------------------------------------------------------
// switch_event_scheduler
//
// Takes the debounced switch levels and turns them into one ordered stream of
// press events. Each switch contributes an event when it is first pressed, and
// further auto-repeat events while it stays held. A switch can have at most one
// pending event. Pending events go to a single consumer through a round-robin
// arbiter and a valid/ready output register.
//
// Ports
//   i_Clk          system clock, all logic on the rising edge
//   i_Reset        synchronous, active-high reset
//   i_Switches     debounced switch levels, 1 = pressed
//   i_Event_Ready  consumer accepts the presented event this cycle
//   o_Event_Valid  an event is being presented
//   o_Event_Id     switch index of the presented event
//   o_Event_Repeat 0 = initial press, 1 = auto-repeat
//   o_Pending      per-switch pending flags (status)
//   o_Overrun      sticky per-switch flag: an event was merged into a pending one
// -----------------------------------------------------------------------------
module switch_event_scheduler #(
    parameter int NUM_SW       = 4,
    parameter int REPEAT_DELAY = 12_500_000,
    parameter int REPEAT_RATE  = 2_500_000,
    parameter int CNT_W        = 24
) (
    input  logic                      i_Clk,
    input  logic                      i_Reset,
    input  logic [NUM_SW-1:0]         i_Switches,
    input  logic                      i_Event_Ready,
    output logic                      o_Event_Valid,
    output logic [$clog2(NUM_SW)-1:0] o_Event_Id,
    output logic                      o_Event_Repeat,
    output logic [NUM_SW-1:0]         o_Pending,
    output logic [NUM_SW-1:0]         o_Overrun
);

    localparam int ID_W = $clog2(NUM_SW);

    logic [NUM_SW-1:0] prev_reg;
    logic [NUM_SW-1:0] press;
    logic [NUM_SW-1:0] rep_fire;
    logic [NUM_SW-1:0] event_hit;

    logic [NUM_SW-1:0] pending_reg;
    logic [NUM_SW-1:0] rep_reg;
    logic [NUM_SW-1:0] overrun_reg;

    logic              valid_reg;
    logic [ID_W-1:0]   id_reg;
    logic              rep_out_reg;
    logic [ID_W-1:0]   last_reg;

    logic              load;
    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;

    // Wrap base+off into 0..NUM_SW-1 (off never exceeds NUM_SW, so a single
    // subtraction is enough and non-power-of-two NUM_SW still works).
    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_SW) begin
            s = s - NUM_SW;
        end
        return ID_W'(s);
    endfunction

    // -------------------------------------------------------------------------
    // Edge detect. prev_reg follows the inputs during reset too, so a switch
    // that is already held when reset releases does not look like a new press.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            prev_reg <= i_Switches;
        end else begin
            prev_reg <= i_Switches;
        end
    end

    assign press     = i_Switches & ~prev_reg;
    assign event_hit = press | rep_fire;

    // -------------------------------------------------------------------------
    // Per-switch hold counter and repeat phase. The counter runs only on held
    // cycles that are not the press itself; when it reaches the limit for the
    // current phase a repeat fires and the counter starts over.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_hold
            logic [CNT_W-1:0] cnt_reg;
            logic             phase_reg;
            logic             at_limit;

            assign at_limit = phase_reg ? (cnt_reg == CNT_W'(REPEAT_RATE - 1))
                                        : (cnt_reg == CNT_W'(REPEAT_DELAY - 1));

            // Held and not a fresh press: only then can a repeat fire, which
            // keeps press and repeat mutually exclusive.
            assign rep_fire[gi] = i_Switches[gi] & prev_reg[gi] & at_limit;

            always_ff @(posedge i_Clk) begin
                if (i_Reset) begin
                    cnt_reg   <= '0;
                    phase_reg <= 1'b0;
                end else if (!i_Switches[gi] || press[gi]) begin
                    cnt_reg   <= '0;
                    phase_reg <= 1'b0;
                end else if (at_limit) begin
                    cnt_reg   <= '0;
                    phase_reg <= 1'b1;
                end else begin
                    cnt_reg   <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Round-robin arbiter: first pending index after the last granted one.
    // -------------------------------------------------------------------------
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_SW; k++) begin
            if (!grant_found && pending_reg[wrap_idx(last_reg, k)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(last_reg, k);
            end
        end
    end

    // The output register can take a new event when it is empty or when its
    // current event is being accepted this cycle (back-to-back transfers).
    assign load = (!valid_reg || i_Event_Ready) && grant_found;

    // -------------------------------------------------------------------------
    // Pending flags, event kinds, overrun flags and output register.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            pending_reg <= '0;
            rep_reg     <= '0;
            overrun_reg <= '0;
            valid_reg   <= 1'b0;
            id_reg      <= '0;
            rep_out_reg <= 1'b0;
            last_reg    <= ID_W'(NUM_SW - 1);
        end else begin
            if (load) begin
                valid_reg   <= 1'b1;
                id_reg      <= grant_idx;
                rep_out_reg <= rep_reg[grant_idx];
                last_reg    <= grant_idx;
            end else if (i_Event_Ready) begin
                valid_reg   <= 1'b0;
            end

            for (int i = 0; i < NUM_SW; i++) begin
                if (event_hit[i]) begin
                    // A new event beats the clear from a same-cycle grant,
                    // and is only an overrun if the old one is not leaving now.
                    pending_reg[i] <= 1'b1;
                    rep_reg[i]     <= rep_fire[i];
                    if (pending_reg[i] && !(load && grant_idx == ID_W'(i))) begin
                        overrun_reg[i] <= 1'b1;
                    end
                end else if (load && grant_idx == ID_W'(i)) begin
                    pending_reg[i] <= 1'b0;
                end
            end
        end
    end

    assign o_Event_Valid  = valid_reg;
    assign o_Event_Id     = id_reg;
    assign o_Event_Repeat = rep_out_reg;
    assign o_Pending      = pending_reg;
    assign o_Overrun      = overrun_reg;

endmodule

// File: tb/tb_switch_event_scheduler.sv
// -----------------------------------------------------------------------------
// Testbench for switch_event_scheduler (NUM_SW=4, REPEAT_DELAY=8, REPEAT_RATE=4).
// A per-cycle vector table, hand-written corner sequences, then a randomized
// run. Every cycle is also checked against a behavioural reference model that
// works from hold durations (age since press) rather than counters.
// -----------------------------------------------------------------------------
module tb_switch_event_scheduler;

    localparam int NSW = 4;
    localparam int D   = 8;
    localparam int R   = 4;

    logic             clk = 1'b0;
    logic             rst_in;
    logic [NSW-1:0]   sw_in;
    logic             rdy_in;
    logic             ev_valid;
    logic [1:0]       ev_id;
    logic             ev_rep;
    logic [NSW-1:0]   pend;
    logic [NSW-1:0]   ovr;

    int n_checks = 0;
    int n_fail   = 0;
    bit verbose  = 1'b1;

    always #5 clk = ~clk;

    switch_event_scheduler #(
        .NUM_SW(NSW),
        .REPEAT_DELAY(D),
        .REPEAT_RATE(R),
        .CNT_W(24)
    ) dut (
        .i_Clk(clk),
        .i_Reset(rst_in),
        .i_Switches(sw_in),
        .i_Event_Ready(rdy_in),
        .o_Event_Valid(ev_valid),
        .o_Event_Id(ev_id),
        .o_Event_Repeat(ev_rep),
        .o_Pending(pend),
        .o_Overrun(ovr)
    );

    // One line per transferred event during the directed part.
    always @(posedge clk) begin
        if (verbose && !rst_in && ev_valid && rdy_in) begin
            $display("[%0t] event id=%0d repeat=%0d", $time, ev_id, ev_rep);
        end
    end

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    logic [NSW-1:0] m_prev, m_pend, m_rep, m_ovr;
    int             m_age[NSW];
    logic           m_valid;
    logic [1:0]     m_id;
    logic           m_erep;
    int             m_last;

    function automatic void model_step(input logic [NSW-1:0] sw, input logic rdy, input logic rst);
        logic [NSW-1:0] ev, kind, old_pend;
        logic           ld;
        int             g;
        if (rst) begin
            m_prev  = sw;
            m_pend  = '0;
            m_rep   = '0;
            m_ovr   = '0;
            m_valid = 1'b0;
            m_id    = '0;
            m_erep  = 1'b0;
            m_last  = NSW - 1;
            for (int i = 0; i < NSW; i++) m_age[i] = 0;
            return;
        end
        ev   = '0;
        kind = '0;
        for (int i = 0; i < NSW; i++) begin
            if (sw[i] && !m_prev[i]) begin
                ev[i]    = 1'b1;
                m_age[i] = 0;
            end else if (sw[i]) begin
                // Events at age D, D+R, D+2R, ... counted from the press cycle.
                m_age[i] = m_age[i] + 1;
                if (m_age[i] == D || (m_age[i] > D && ((m_age[i] - D) % R) == 0)) begin
                    ev[i]   = 1'b1;
                    kind[i] = 1'b1;
                end
            end else begin
                m_age[i] = 0;
            end
        end
        old_pend = m_pend;
        g = -1;
        for (int k = 1; k <= NSW; k++) begin
            if (g < 0 && old_pend[(m_last + k) % NSW]) g = (m_last + k) % NSW;
        end
        ld = (!m_valid || rdy) && (g >= 0);
        if (ld) begin
            m_valid   = 1'b1;
            m_id      = 2'(g);
            m_erep    = m_rep[g];
            m_last    = g;
            m_pend[g] = 1'b0;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        for (int i = 0; i < NSW; i++) begin
            if (ev[i]) begin
                if (old_pend[i] && !(ld && g == i)) m_ovr[i] = 1'b1;
                m_pend[i] = 1'b1;
                m_rep[i]  = kind[i];
            end
        end
        m_prev = sw;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_compare();
        check("model_valid", 32'(ev_valid), 32'(m_valid));
        if (m_valid) begin
            check("model_id", 32'(ev_id), 32'(m_id));
            check("model_repeat", 32'(ev_rep), 32'(m_erep));
        end
        check("model_pending", 32'(pend), 32'(m_pend));
        check("model_overrun", 32'(ovr), 32'(m_ovr));
    endtask

    // Drive inputs, let one edge pass, then compare 1 time unit after it.
    task automatic step(input logic [NSW-1:0] sw, input logic rdy, input logic rst);
        sw_in  = sw;
        rdy_in = rdy;
        rst_in = rst;
        @(posedge clk);
        #1;
        model_step(sw, rdy, rst);
        model_compare();
    endtask

    // ------------------------------------------------------------------------
    // Vector table
    // ------------------------------------------------------------------------
    typedef struct {
        logic [NSW-1:0] sw;
        logic           rdy;
        logic           rst;
        logic           v;
        logic [1:0]     id;
        logic           rep;
        logic [NSW-1:0] pnd;
        logic [NSW-1:0] ov;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [NSW-1:0] sw, input logic rdy, input logic rst,
                                input logic v, input logic [1:0] id, input logic [NSW-1:0] pnd);
        vec_t t;
        t.sw = sw; t.rdy = rdy; t.rst = rst;
        t.v = v; t.id = id; t.rep = 1'b0; t.pnd = pnd; t.ov = '0;
        tbl.push_back(t);
    endfunction

    int cnt;
    int ev_steps[$];
    logic ev_reps[$];

    initial begin
        sw_in  = '0;
        rdy_in = 1'b0;
        rst_in = 1'b1;

        // Pulse switch 2 for 3 cycles; then all four together from reset;
        // then make last=1 and press all four again.
        add(4'b0000, 1, 1, 0, 0, 4'b0000);
        add(4'b0100, 1, 0, 0, 0, 4'b0100);
        add(4'b0100, 1, 0, 1, 2, 4'b0000);
        add(4'b0100, 1, 0, 0, 0, 4'b0000);
        add(4'b0000, 1, 1, 0, 0, 4'b0000);
        add(4'b1111, 1, 0, 0, 0, 4'b1111);
        add(4'b1111, 1, 0, 1, 0, 4'b1110);
        add(4'b1111, 1, 0, 1, 1, 4'b1100);
        add(4'b1111, 1, 0, 1, 2, 4'b1000);
        add(4'b1111, 1, 0, 1, 3, 4'b0000);
        add(4'b0000, 1, 0, 0, 0, 4'b0000);
        add(4'b0010, 1, 0, 0, 0, 4'b0010);
        add(4'b0010, 1, 0, 1, 1, 4'b0000);
        add(4'b0000, 1, 0, 0, 0, 4'b0000);
        add(4'b1111, 1, 0, 0, 0, 4'b1111);
        add(4'b1111, 1, 0, 1, 2, 4'b1011);
        add(4'b1111, 1, 0, 1, 3, 4'b0011);
        add(4'b1111, 1, 0, 1, 0, 4'b0010);
        add(4'b1111, 1, 0, 1, 1, 4'b0000);
        add(4'b0000, 1, 0, 0, 0, 4'b0000);

        foreach (tbl[n]) begin
            step(tbl[n].sw, tbl[n].rdy, tbl[n].rst);
            check("tbl_valid", 32'(ev_valid), 32'(tbl[n].v));
            if (tbl[n].v) begin
                check("tbl_id", 32'(ev_id), 32'(tbl[n].id));
                check("tbl_repeat", 32'(ev_rep), 32'(tbl[n].rep));
            end
            check("tbl_pending", 32'(pend), 32'(tbl[n].pnd));
            check("tbl_overrun", 32'(ovr), 32'(tbl[n].ov));
        end

        // Hold switch 1 for 20 cycles: events at +1, +9, +13, +17 steps.
        step(4'b0000, 1, 1);
        for (int k = 0; k < 30; k++) begin
            step((k < 20) ? 4'b0010 : 4'b0000, 1, 0);
            if (ev_valid) begin
                ev_steps.push_back(k);
                ev_reps.push_back(ev_rep);
            end
        end
        check("hold_event_count", 32'(ev_steps.size()), 32'd4);
        if (ev_steps.size() == 4) begin
            check("hold_ev0_step", 32'(ev_steps[0]), 32'd1);
            check("hold_ev1_step", 32'(ev_steps[1]), 32'd9);
            check("hold_ev2_step", 32'(ev_steps[2]), 32'd13);
            check("hold_ev3_step", 32'(ev_steps[3]), 32'd17);
            check("hold_ev0_rep", 32'(ev_reps[0]), 32'd0);
            check("hold_ev1_rep", 32'(ev_reps[1]), 32'd1);
            check("hold_ev3_rep", 32'(ev_reps[3]), 32'd1);
        end

        // Stalled consumer, switch 3 pressed three times.
        step(4'b0000, 0, 1);
        step(4'b1000, 0, 0);
        check("stall_pend1", 32'(pend), 32'b1000);
        step(4'b0000, 0, 0);
        check("stall_valid", 32'(ev_valid), 32'd1);
        check("stall_id", 32'(ev_id), 32'd3);
        step(4'b1000, 0, 0);
        check("stall_pend2", 32'(pend), 32'b1000);
        check("stall_id_hold", 32'(ev_id), 32'd3);
        step(4'b0000, 0, 0);
        step(4'b1000, 0, 0);
        check("stall_overrun", 32'(ovr), 32'b1000);
        check("stall_valid_hold", 32'(ev_valid), 32'd1);
        step(4'b0000, 1, 0);
        check("stall_second_valid", 32'(ev_valid), 32'd1);
        check("stall_second_id", 32'(ev_id), 32'd3);
        check("stall_pend_empty", 32'(pend), 32'd0);
        step(4'b0000, 1, 0);
        check("stall_drained", 32'(ev_valid), 32'd0);
        check("stall_overrun_sticky", 32'(ovr), 32'b1000);

        // Switch 0 held through reset: no press; re-press gives one event.
        step(4'b0001, 1, 1);
        step(4'b0001, 1, 1);
        cnt = 0;
        for (int k = 0; k < 5; k++) begin
            step(4'b0001, 1, 0);
            if (ev_valid || pend != 0) cnt++;
        end
        check("held_reset_no_event", 32'(cnt), 32'd0);
        step(4'b0000, 1, 0);
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step((k < 2) ? 4'b0001 : 4'b0000, 1, 0);
            if (ev_valid) begin
                cnt++;
                check("repress_id", 32'(ev_id), 32'd0);
            end
        end
        check("repress_count", 32'(cnt), 32'd1);

        // Reset while an event is presented and pending = 1010.
        step(4'b0000, 0, 1);
        step(4'b0001, 0, 0);
        step(4'b0000, 0, 0);
        step(4'b1010, 0, 0);
        check("pre_rst_valid", 32'(ev_valid), 32'd1);
        check("pre_rst_pend", 32'(pend), 32'b1010);
        step(4'b1010, 0, 1);
        check("rst_valid", 32'(ev_valid), 32'd0);
        check("rst_id", 32'(ev_id), 32'd0);
        check("rst_repeat", 32'(ev_rep), 32'd0);
        check("rst_pend", 32'(pend), 32'd0);
        check("rst_overrun", 32'(ovr), 32'd0);
        cnt = 0;
        for (int k = 0; k < 7; k++) begin
            step((k < 5) ? 4'b1010 : 4'b0000, 1, 0);
            if (ev_valid || pend != 0) cnt++;
        end
        check("post_rst_quiet", 32'(cnt), 32'd0);

        // Randomized run against the model.
        verbose = 1'b0;
        begin
            logic [NSW-1:0] cur;
            int             rdy_pct;
            cur = '0;
            step(cur, 1, 1);
            for (int c = 0; c < 4000; c++) begin
                if (c % 250 == 0) rdy_pct = (c % 500 == 0) ? 90 : 25;
                for (int i = 0; i < NSW; i++) begin
                    if ($urandom_range(0, 19) == 0) cur[i] = ~cur[i];
                end
                step(cur, ($urandom_range(0, 99) < rdy_pct), ($urandom_range(0, 599) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
